// File: rtl/dxm_dff_if.sv
// Data-path bundle for dxm_dff: data in, last-stage output and all stage outputs.
// The stage load enable ce exists only when DXM_DFF_CE_EN is defined.
interface dxm_dff_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
);
  logic [WIDTH-1:0]       d;
`ifdef DXM_DFF_CE_EN
  logic                   ce;
`endif
  logic [WIDTH-1:0]       q;
  logic [WIDTH*DEPTH-1:0] q_stg;

`ifdef DXM_DFF_CE_EN
  modport master (output d, output ce, input q, input q_stg);
  modport slave  (input d, input ce, output q, output q_stg);
`else
  modport master (output d, input q, input q_stg);
  modport slave  (input d, output q, output q_stg);
`endif
endinterface

// File: rtl/dxm_dff.sv
// dxm_dff: parameterised register chain of DEPTH stages, WIDTH bits each.
// Synchronous active-high reset loads RST_VAL (truncated/zero-extended to WIDTH)
// into every stage. Optional macro DXM_DFF_CE_EN adds a single load enable ce
// shared by all stages; without it the chain shifts on every clock rise.
module dxm_dff #(
  parameter int WIDTH   = 1,
  parameter int DEPTH   = 1,
  parameter     RST_VAL = 0
) (
  input  logic     clk,
  input  logic     rst,
  dxm_dff_if.slave bus
);

  // Fit the reset value to the data width: wider is truncated, narrower zero-extended.
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  // Nonsense geometry must never elaborate silently.
  if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
    $fatal(1, "dxm_dff %m: illegal parameters WIDTH=%0d DEPTH=%0d (both must be >= 1)",
           WIDTH, DEPTH);
  end

  // One enable for the whole chain so stages can never shift partially.
  logic ld;
`ifdef DXM_DFF_CE_EN
  assign ld = bus.ce;
`else
  assign ld = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stg
      logic [WIDTH-1:0] stg_reg;
      logic [WIDTH-1:0] stg_next;

      // Stage 0 takes the input; later stages take their predecessor.
      if (gi == 0) begin : g_first
        assign stg_next = bus.d;
      end else begin : g_chain
        assign stg_next = g_stg[gi-1].stg_reg;
      end

      // Stage register: reset wins over load, otherwise hold when not loading.
      always_ff @(posedge clk) begin
        if (rst) begin
          stg_reg <= RST_V;
        end else if (ld) begin
          stg_reg <= stg_next;
        end
      end

      // Every stage is visible straight from its flop.
      assign bus.q_stg[gi*WIDTH +: WIDTH] = stg_reg;
    end
  endgenerate

  // Last stage drives q directly.
  assign bus.q = g_stg[DEPTH-1].stg_reg;

endmodule

// File: tb/tb_dxm_dff.sv
// Testbench for dxm_dff: three instances (1x1, 8x2 with RST_VAL A5, 4x3 with an
// over-wide RST_VAL that must truncate to 9) driven in lockstep. Expected values
// come from a history model: each stage k shows the k-th most recent accepted
// sample since the last reset, or the reset value if that many have not arrived.
module tb_dxm_dff;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b1;
  logic [7:0] d_val = 8'h00;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  dxm_dff_if #(.WIDTH(1), .DEPTH(1)) if1 ();
  dxm_dff_if #(.WIDTH(8), .DEPTH(2)) if2 ();
  dxm_dff_if #(.WIDTH(4), .DEPTH(3)) if3 ();

  assign if1.d = d_val[0];
  assign if2.d = d_val;
  assign if3.d = d_val[3:0];
`ifdef DXM_DFF_CE_EN
  assign if1.ce = ce;
  assign if2.ce = ce;
  assign if3.ce = ce;
`endif

  dxm_dff #(.WIDTH(1), .DEPTH(1), .RST_VAL(0))       u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  dxm_dff #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'hA5))   u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  dxm_dff #(.WIDTH(4), .DEPTH(3), .RST_VAL(12'h739)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  // History of accepted samples since reset, newest first.
  logic [7:0] h1[$];
  logic [7:0] h2[$];
  logic [7:0] h3[$];

  function automatic logic [7:0] e1(int k);
    return (k < h1.size()) ? h1[k] : 8'h00;
  endfunction
  function automatic logic [7:0] e2(int k);
    return (k < h2.size()) ? h2[k] : 8'hA5;
  endfunction
  function automatic logic [7:0] e3(int k);
    return (k < h3.size()) ? h3[k] : 8'h09;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model by what the DUTs see at this clock edge.
  task automatic model_edge();
    logic load;
`ifdef DXM_DFF_CE_EN
    load = ce;
`else
    load = 1'b1;
`endif
    if (rst) begin
      h1.delete();
      h2.delete();
      h3.delete();
    end else if (load) begin
      h1.push_front({7'd0, d_val[0]});
      h2.push_front(d_val);
      h3.push_front({4'd0, d_val[3:0]});
      while (h1.size() > 1) void'(h1.pop_back());
      while (h2.size() > 2) void'(h2.pop_back());
      while (h3.size() > 3) void'(h3.pop_back());
    end
  endtask

  task automatic check_all();
    check_val("q1", 64'(if1.q), 64'(e1(0)));
    check_val("stg1", 64'(if1.q_stg), 64'(e1(0)));
    for (int k = 0; k < 2; k++)
      check_val($sformatf("stg2_%0d", k), 64'(if2.q_stg[k*8 +: 8]), 64'(e2(k)));
    check_val("q2", 64'(if2.q), 64'(e2(1)));
    for (int k = 0; k < 3; k++)
      check_val($sformatf("stg3_%0d", k), 64'(if3.q_stg[k*4 +: 4]), 64'(e3(k)));
    check_val("q3", 64'(if3.q), 64'(e3(2)));
  endtask

  // One clock: edge, model update, then sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    $display("cyc %0d rst=%0b ce=%0b d=%02h q1=%0h q2=%02h q3=%0h stg2=%04h stg3=%03h",
             cyc, rst, ce, d_val, if1.q, if2.q, if3.q, if2.q_stg, if3.q_stg);
    check_all();
  endtask

  initial begin
    logic [7:0]  s2;
    logic [15:0] sstg2;
    logic [11:0] sstg3;

    // Reset state
    rst = 1'b1; ce = 1'b1; d_val = 8'h5A;
    tick();
    check_val("rst_q1", 64'(if1.q), 64'h0);
    check_val("rst_q2", 64'(if2.q), 64'hA5);
    check_val("rst_stg2", 64'(if2.q_stg), 64'hA5A5);
    check_val("rst_stg3_trunc", 64'(if3.q_stg), 64'h999);

    // 1-bit register follows d with one edge of latency
    rst = 1'b0; d_val = 8'h01;
    tick();
    check_val("t1_q1_hi", 64'(if1.q), 64'h1);
    d_val = 8'h00;
    tick();
    check_val("t1_q1_lo", 64'(if1.q), 64'h0);

    // 8x2: 3C lands in stage 0 first, on q one edge later
    d_val = 8'h3C;
    tick();
    check_val("t2_stg0", 64'(if2.q_stg[7:0]), 64'h3C);
    d_val = 8'h11;
    tick();
    check_val("t2_q2", 64'(if2.q), 64'h3C);

    // Reset mid-stream flushes the 4x3 chain
    for (int i = 1; i <= 3; i++) begin
      d_val = 8'(i);
      tick();
    end
    rst = 1'b1; d_val = 8'h04;
    tick();
    check_val("t3_flush", 64'(if3.q_stg), 64'h999);
    rst = 1'b0; d_val = 8'h04;
    tick();
    check_val("t3_lat1", 64'(if3.q), 64'h9);
    d_val = 8'h07;
    tick();
    check_val("t3_lat2", 64'(if3.q), 64'h9);
    d_val = 8'h08;
    tick();
    check_val("t3_lat3", 64'(if3.q), 64'h4);

    // Toggle rst and d between edges: nothing may change without a clock rise
    s2 = if2.q; sstg3 = if3.q_stg;
    rst = 1'b1; d_val = ~d_val;
    #2;
    rst = 1'b0; d_val = 8'hE7;
    #1;
    check_val("t5_q2_hold", 64'(if2.q), 64'(s2));
    check_val("t5_stg3_hold", 64'(if3.q_stg), 64'(sstg3));
    tick();

`ifdef DXM_DFF_CE_EN
    // Enable low freezes every stage even with changing d
    sstg2 = if2.q_stg; sstg3 = if3.q_stg;
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_val = 8'($urandom);
      tick();
      check_val("t4_stg2_frz", 64'(if2.q_stg), 64'(sstg2));
      check_val("t4_stg3_frz", 64'(if3.q_stg), 64'(sstg3));
    end
    ce = 1'b1; d_val = 8'hC3;
    tick();
    check_val("t4_resume", 64'(if2.q_stg[7:0]), 64'hC3);
    rst = 1'b1; ce = 1'b0;
    tick();
    check_val("t4_rst_ce0", 64'(if2.q), 64'hA5);
    rst = 1'b0;
`endif

    // Random traffic against the history model
    for (int i = 0; i < 200; i++) begin
      rst   = ($urandom_range(0, 19) == 0);
`ifdef DXM_DFF_CE_EN
      ce    = ($urandom_range(0, 3) != 0);
`endif
      d_val = 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
